// File: rtl/door_lock_ctrl.sv
// door_lock_ctrl: keypad door lock with a main password, a one-shot temporary
// password, two programming modes and a lockout after repeated failures.
//
// Key inputs are one-cycle strobes (KEY_VALID). Codes 0-9 are digits,
// 10 is STAR, 11 is HASH and 12-15 are ignored everywhere.
// STAR, HASH and PW_TEMP_RESET are one-cycle pulses towards the password
// store. They are never handshaked, so the store must accept them on the
// cycle they are high. Every output comes straight from a flop.
// DBG_STATE exposes the FSM state register for observation.
module door_lock_ctrl #(
  parameter int UNLOCK_CYCLES  = 16,
  parameter int LOCKOUT_CYCLES = 64,
  parameter int MAX_FAIL       = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        KEY_VALID,
  input  logic [3:0]  KEY_CODE,
  input  logic [15:0] PW,
  input  logic [15:0] PW_TEMP,
  input  logic        PW_TEMP_VALID,
  output logic [15:0] DISPLAY,
  output logic        CORRECT,
  output logic        STAR,
  output logic        HASH,
  output logic        PW_TEMP_RESET,
  output logic        UNLOCK,
  output logic        ALARM,
  output logic [1:0]  FAIL_CNT,
  output logic [2:0]  DBG_STATE
);

  typedef enum logic [2:0] {
    ENTRY     = 3'd0,
    CHECK     = 3'd1,
    OPEN      = 3'd2,
    PROG_PW   = 3'd3,
    PROG_TEMP = 3'd4,
    LOCKOUT   = 3'd5
  } state_e;

  // One shared down-counter serves OPEN, the programming idle timeout and
  // LOCKOUT, so it is sized for the longest of the two intervals.
  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] UNLOCK_LOAD = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD   = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_ZERO      = '0;
  localparam logic [TW-1:0] T_ONE       = TW'(1);
  localparam logic [1:0]    MAX_FAIL_L  = 2'(MAX_FAIL);

  state_e        state_q, state_d;
  logic [15:0]   display_q, display_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          commit_q, commit_d;
  logic          correct_q, correct_d;
  logic          star_q, star_d;
  logic          hash_q, hash_d;
  logic          ptr_q, ptr_d;
  logic          unlock_q, unlock_d;
  logic          alarm_q, alarm_d;
  logic [1:0]    fail_cnt_q, fail_cnt_d;

  logic          key_digit, key_star, key_hash, key_term;
  logic [15:0]   display_shift;
  logic [2:0]    cnt_inc;
  logic [1:0]    fail_new;

  assign key_digit     = KEY_VALID && (KEY_CODE <= 4'd9);
  assign key_star      = KEY_VALID && (KEY_CODE == 4'd10);
  assign key_hash      = KEY_VALID && (KEY_CODE == 4'd11);
  assign key_term      = (state_q == PROG_PW) ? key_star : key_hash;
  assign display_shift = {display_q[11:0], KEY_CODE};
  assign cnt_inc       = (cnt_q == 3'd4) ? 3'd4 : cnt_q + 3'd1;
  assign fail_new      = (fail_cnt_q == 2'd3) ? 2'd3 : fail_cnt_q + 2'd1;

  // Next-state and next-output logic for the lock FSM.
  always_comb begin
    state_d    = state_q;
    display_d  = display_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    commit_d   = 1'b0;
    correct_d  = correct_q;
    star_d     = 1'b0;
    hash_d     = 1'b0;
    ptr_d      = 1'b0;
    fail_cnt_d = fail_cnt_q;

    case (state_q)
      ENTRY: begin
        if (key_digit) begin
          display_d = display_shift;
          cnt_d     = cnt_inc;
        end else if (key_star) begin
          display_d = '0;
          cnt_d     = '0;
        end else if (key_hash) begin
          if (cnt_q == 3'd4) begin
            state_d = CHECK;
          end else begin
            display_d = '0;
            cnt_d     = '0;
          end
        end
      end

      // Single-cycle comparison; a main match wins over a temporary match
      // so the temporary password survives when both are equal.
      CHECK: begin
        cnt_d = '0;
        if (display_q == PW) begin
          state_d    = OPEN;
          correct_d  = 1'b1;
          fail_cnt_d = '0;
          timer_d    = UNLOCK_LOAD;
        end else if (PW_TEMP_VALID && (display_q == PW_TEMP)) begin
          state_d    = OPEN;
          correct_d  = 1'b0;
          ptr_d      = 1'b1;
          fail_cnt_d = '0;
          timer_d    = UNLOCK_LOAD;
        end else begin
          correct_d  = 1'b0;
          display_d  = '0;
          fail_cnt_d = fail_new;
          if (fail_new == MAX_FAIL_L) begin
            state_d = LOCKOUT;
            timer_d = LOCK_LOAD;
          end else begin
            state_d = ENTRY;
          end
        end
      end

      OPEN: begin
        if (correct_q && key_star) begin
          state_d   = PROG_PW;
          star_d    = 1'b1;
          display_d = '0;
          cnt_d     = '0;
          timer_d   = UNLOCK_LOAD;
        end else if (correct_q && key_hash) begin
          state_d   = PROG_TEMP;
          hash_d    = 1'b1;
          display_d = '0;
          cnt_d     = '0;
          timer_d   = UNLOCK_LOAD;
        end else if (timer_q == T_ZERO) begin
          state_d   = ENTRY;
          correct_d = 1'b0;
          display_d = '0;
          cnt_d     = '0;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end

      // A complete terminator spends one commit cycle here with the pulse
      // high and DISPLAY still holding the new password, then leaves.
      PROG_PW, PROG_TEMP: begin
        if (commit_q) begin
          state_d   = ENTRY;
          correct_d = 1'b0;
          display_d = '0;
          cnt_d     = '0;
        end else if (key_digit) begin
          display_d = display_shift;
          cnt_d     = cnt_inc;
          timer_d   = UNLOCK_LOAD;
        end else if (key_term) begin
          if (cnt_q == 3'd4) begin
            commit_d = 1'b1;
            star_d   = (state_q == PROG_PW);
            hash_d   = (state_q == PROG_TEMP);
            timer_d  = UNLOCK_LOAD;
          end else begin
            state_d   = ENTRY;
            correct_d = 1'b0;
            display_d = '0;
            cnt_d     = '0;
          end
        end else if (timer_q == T_ZERO) begin
          state_d   = ENTRY;
          correct_d = 1'b0;
          display_d = '0;
          cnt_d     = '0;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end

      LOCKOUT: begin
        if (timer_q == T_ZERO) begin
          state_d    = ENTRY;
          fail_cnt_d = '0;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end

      default: begin
        state_d   = ENTRY;
        correct_d = 1'b0;
        display_d = '0;
        cnt_d     = '0;
      end
    endcase
  end

  // Level outputs follow the state being entered so they line up with it.
  always_comb begin
    unlock_d = (state_d == OPEN);
    alarm_d  = (state_d == LOCKOUT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ENTRY;
      display_q  <= '0;
      cnt_q      <= '0;
      timer_q    <= '0;
      commit_q   <= 1'b0;
      correct_q  <= 1'b0;
      star_q     <= 1'b0;
      hash_q     <= 1'b0;
      ptr_q      <= 1'b0;
      unlock_q   <= 1'b0;
      alarm_q    <= 1'b0;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      display_q  <= display_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      commit_q   <= commit_d;
      correct_q  <= correct_d;
      star_q     <= star_d;
      hash_q     <= hash_d;
      ptr_q      <= ptr_d;
      unlock_q   <= unlock_d;
      alarm_q    <= alarm_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign DISPLAY       = display_q;
  assign CORRECT       = correct_q;
  assign STAR          = star_q;
  assign HASH          = hash_q;
  assign PW_TEMP_RESET = ptr_q;
  assign UNLOCK        = unlock_q;
  assign ALARM         = alarm_q;
  assign FAIL_CNT      = fail_cnt_q;
  assign DBG_STATE     = state_q;

endmodule
